// File: rtl/png_chunk_chk.sv
// rtl/png_chunk_chk.sv - PNG chunk parser: length/type header, payload stream, CRC-32 check.
// Optional CRC computation/compare enabled by macro PNG_CHUNK_CHK_CRC_EN (crc_ok_o tied to 1 otherwise).
module png_chunk_chk #(
    parameter int DATA_WD = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start_i,
    input  logic               val_i,
    input  logic [7:0]         dat_i,
    output logic               hdr_val_o,
    output logic [DATA_WD-1:0] len_o,
    output logic [DATA_WD-1:0] typ_o,
    output logic               val_o,
    output logic [7:0]         dat_o,
    output logic               lst_o,
    output logic               done_o,
    output logic               crc_ok_o,
    output logic               err_o
);

    typedef enum logic [2:0] {IDLE, LEN, TYP, DAT, CRC, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  cnt;
    logic [31:0] pcnt;
    logic [31:0] len_q;
    logic [31:0] typ_q;
    logic        err_q;
    logic        crc_match;

    assign len_o = DATA_WD'(len_q);
    assign typ_o = DATA_WD'(typ_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // start_i wins over everything, including a byte presented in the same cycle
    always_comb begin
        state_nxt = state;
        if (start_i) begin
            state_nxt = LEN;
        end else begin
            case (state)
                IDLE: state_nxt = IDLE;
                LEN:  if (val_i && cnt == 2'd3) state_nxt = TYP;
                TYP:  if (val_i && cnt == 2'd3) state_nxt = (len_q[31] || len_q == 32'd0) ? CRC : DAT;
                DAT:  if (val_i && pcnt == 32'd1) state_nxt = CRC;
                CRC:  if (val_i && cnt == 2'd3) state_nxt = DONE;
                DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= 2'd0;
            pcnt      <= 32'd0;
            len_q     <= 32'd0;
            typ_q     <= 32'd0;
            err_q     <= 1'b0;
            hdr_val_o <= 1'b0;
            val_o     <= 1'b0;
            dat_o     <= 8'd0;
            lst_o     <= 1'b0;
            done_o    <= 1'b0;
            crc_ok_o  <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            hdr_val_o <= 1'b0;
            val_o     <= 1'b0;
            lst_o     <= 1'b0;
            done_o    <= 1'b0;
            crc_ok_o  <= 1'b0;
            err_o     <= 1'b0;
            if (start_i) begin
                cnt   <= 2'd0;
                pcnt  <= 32'd0;
                err_q <= 1'b0;
            end else if (val_i) begin
                case (state)
                    LEN: begin
                        len_q <= {len_q[23:0], dat_i};
                        cnt   <= cnt + 2'd1;
                    end
                    TYP: begin
                        typ_q <= {typ_q[23:0], dat_i};
                        cnt   <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            hdr_val_o <= 1'b1;
                            pcnt      <= len_q;
                            err_q     <= len_q[31];
                        end
                    end
                    DAT: begin
                        val_o <= 1'b1;
                        dat_o <= dat_i;
                        lst_o <= (pcnt == 32'd1);
                        pcnt  <= pcnt - 32'd1;
                    end
                    CRC: cnt <= cnt + 2'd1;
                    default: ;
                endcase
            end
            if (state == DONE && !start_i) begin
                done_o   <= 1'b1;
                crc_ok_o <= crc_match;
                err_o    <= err_q;
            end
        end
    end

`ifdef PNG_CHUNK_CHK_CRC_EN
    logic [31:0] crc_q;
    logic [31:0] rx_crc_q;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // CRC covers type and payload only; received CRC arrives MSB-first
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crc_q    <= 32'hFFFFFFFF;
            rx_crc_q <= 32'd0;
        end else if (start_i) begin
            crc_q    <= 32'hFFFFFFFF;
            rx_crc_q <= 32'd0;
        end else if (val_i && (state == TYP || state == DAT)) begin
            crc_q <= crc_byte(crc_q, dat_i);
        end else if (val_i && state == CRC) begin
            rx_crc_q <= {rx_crc_q[23:0], dat_i};
        end
    end

    assign crc_match = ((crc_q ^ 32'hFFFFFFFF) == rx_crc_q);
`else
    assign crc_match = 1'b1;
`endif

endmodule

// File: tb/tb_png_chunk_chk.sv
// tb/tb_png_chunk_chk.sv - scoreboard bench for png_chunk_chk with directed chunk streams.
module tb_png_chunk_chk;

    logic        clk;
    logic        rstn;
    logic        start_i;
    logic        val_i;
    logic [7:0]  dat_i;
    logic        hdr_val_o;
    logic [31:0] len_o;
    logic [31:0] typ_o;
    logic        val_o;
    logic [7:0]  dat_o;
    logic        lst_o;
    logic        done_o;
    logic        crc_ok_o;
    logic        err_o;

    png_chunk_chk #(.DATA_WD(32)) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .val_i(val_i), .dat_i(dat_i),
        .hdr_val_o(hdr_val_o), .len_o(len_o), .typ_o(typ_o),
        .val_o(val_o), .dat_o(dat_o), .lst_o(lst_o),
        .done_o(done_o), .crc_ok_o(crc_ok_o), .err_o(err_o)
    );

    typedef struct {
        int          kind;   // 0 header, 1 payload byte, 2 done
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;    // expected sample cycle, -1 for don't care
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic pop_check(input int kind, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_output: got kind %0d (a=%h b=%h) with empty queue", kind, a, b);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            if (kind == e.kind) begin
                check(kind == 0 ? "len_o" : kind == 1 ? "dat_o" : "crc_ok_o", a, e.a);
                check(kind == 0 ? "typ_o" : kind == 1 ? "lst_o" : "err_o", b, e.b);
                if (e.cyc >= 0) check(kind == 0 ? "hdr_cycle" : "dat_cycle", cyc, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (lst_o)     check("lst_needs_val", val_o, 1);
            if (hdr_val_o) pop_check(0, len_o, typ_o);
            if (val_o)     pop_check(1, {24'd0, dat_o}, {31'd0, lst_o});
            if (done_o)    pop_check(2, {31'd0, crc_ok_o}, {31'd0, err_o});
        end
    end

    function automatic logic [31:0] crc_of(input logic [7:0] d[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (d[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ d[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, output int acc);
        val_i = 1'b1;
        dat_i = b;
        tick();
        acc   = cyc;
        val_i = 1'b0;
        dat_i = 8'h00;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_hdr_val"}, hdr_val_o, 0);
        check({tag, "_val"},     val_o, 0);
        check({tag, "_lst"},     lst_o, 0);
        check({tag, "_done"},    done_o, 0);
        check({tag, "_crc_ok"},  crc_ok_o, 0);
        check({tag, "_err"},     err_o, 0);
        check({tag, "_len"},     len_o, 0);
        check({tag, "_typ"},     typ_o, 0);
        check({tag, "_dat"},     dat_o, 0);
    endtask

    task automatic send_chunk(input bit do_start, input logic [31:0] len, input logic [31:0] typ,
                              input logic [7:0] pay[$], input logic [31:0] crc, input int gap,
                              input logic exp_ok, input logic exp_err);
        int acc;
        if (do_start) begin
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
        end
        for (int i = 3; i >= 0; i--) begin
            send_byte(len[8*i +: 8], acc);
            repeat (gap) tick();
        end
        for (int i = 3; i >= 0; i--) begin
            send_byte(typ[8*i +: 8], acc);
            if (i == 0) exp_q.push_back('{kind: 0, a: len, b: typ, cyc: acc});
            repeat (gap) tick();
        end
        if (len != 32'd0 && !len[31]) begin
            foreach (pay[i]) begin
                send_byte(pay[i], acc);
                exp_q.push_back('{kind: 1, a: {24'd0, pay[i]}, b: (i == pay.size() - 1) ? 32'd1 : 32'd0, cyc: acc});
                repeat (gap) tick();
            end
        end
        for (int i = 3; i >= 0; i--) begin
            send_byte(crc[8*i +: 8], acc);
            if (i > 0) repeat (gap) tick();
        end
        exp_q.push_back('{kind: 2, a: {31'd0, exp_ok}, b: {31'd0, exp_err}, cyc: -1});
        repeat (4) tick();
    endtask

    logic [7:0] pay_none[$];
    logic [7:0] pay_abc[$];
    logic [7:0] txt_all[$];
    logic [31:0] txt_crc;
    logic       bad_ok;
    int         acc;

    initial begin
        rstn    = 1'b0;
        start_i = 1'b0;
        val_i   = 1'b0;
        dat_i   = 8'h00;
        pay_abc.push_back(8'h41);
        pay_abc.push_back(8'h42);
        pay_abc.push_back(8'h43);
        txt_all.push_back(8'h74);
        txt_all.push_back(8'h45);
        txt_all.push_back(8'h58);
        txt_all.push_back(8'h74);
        txt_all.push_back(8'h41);
        txt_all.push_back(8'h42);
        txt_all.push_back(8'h43);
        txt_crc = crc_of(txt_all);
`ifdef PNG_CHUNK_CHK_CRC_EN
        bad_ok = 1'b0;
`else
        bad_ok = 1'b1;
`endif
        repeat (3) tick();
        check_outputs_zero("reset");
        rstn = 1'b1;
        repeat (2) tick();

        // IEND, correct CRC
        send_chunk(1, 32'h0, 32'h49454E44, pay_none, 32'hAE426082, 0, 1'b1, 1'b0);
        // IEND, corrupted last CRC byte
        send_chunk(1, 32'h0, 32'h49454E44, pay_none, 32'hAE426083, 0, bad_ok, 1'b0);
        // tEXt with 3 payload bytes
        send_chunk(1, 32'h3, 32'h74455874, pay_abc, txt_crc, 0, 1'b1, 1'b0);
        // IEND with 3 idle cycles between bytes
        send_chunk(1, 32'h0, 32'h49454E44, pay_none, 32'hAE426082, 3, 1'b1, 1'b0);
        // oversize length: header reported, payload skipped, error flagged
        send_chunk(1, 32'h80000000, 32'h49454E44, pay_none, 32'hAE426082, 0, 1'b1, 1'b1);

        // abort after 6 bytes, restart pulse carries a byte that must be ignored
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        send_byte(8'h00, acc); send_byte(8'h00, acc); send_byte(8'h00, acc);
        send_byte(8'h00, acc); send_byte(8'h49, acc); send_byte(8'h45, acc);
        start_i = 1'b1;
        val_i   = 1'b1;
        dat_i   = 8'hFF;
        tick();
        start_i = 1'b0;
        val_i   = 1'b0;
        send_chunk(0, 32'h0, 32'h49454E44, pay_none, 32'hAE426082, 0, 1'b1, 1'b0);

        // reset mid-payload, then a complete IEND
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 3; i >= 0; i--) send_byte(8'(32'h3 >> (8*i)), acc);
        for (int i = 3; i >= 0; i--) begin
            send_byte(8'(32'h74455874 >> (8*i)), acc);
            if (i == 0) exp_q.push_back('{kind: 0, a: 32'h3, b: 32'h74455874, cyc: acc});
        end
        send_byte(8'h41, acc);
        exp_q.push_back('{kind: 1, a: 32'h41, b: 32'h0, cyc: acc});
        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check_outputs_zero("midreset");
        tick();
        rstn = 1'b1;
        repeat (3) send_byte(8'h42, acc);
        repeat (2) tick();
        send_chunk(1, 32'h0, 32'h49454E44, pay_none, 32'hAE426082, 0, 1'b1, 1'b0);

        repeat (20) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
